// File: rtl/vedic_result_output_stage.sv
// Output stage of the vector Vedic multiplier: per-lane sign correction, half
// selection and a 2-entry registered valid/ready buffer toward the consumer.
module vedic_result_output_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [2*DATA_WIDTH-1:0] product_in,
    input  logic [3:0]              neg_in,
    input  logic [1:0]              opcode_in,
    input  logic [1:0]              precision_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WIDTH-1:0]   result_out,
    output logic                    illegal_out
);

    localparam logic [1:0] PREC_8  = 2'b00;
    localparam logic [1:0] PREC_16 = 2'b01;
    localparam logic [1:0] PREC_32 = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b00;

    function automatic logic [15:0] neg_lane16(input logic [15:0] p, input logic n);
        return n ? (~p + 16'd1) : p;
    endfunction

    function automatic logic [31:0] neg_lane32(input logic [31:0] p, input logic n);
        return n ? (~p + 32'd1) : p;
    endfunction

    function automatic logic [63:0] neg_lane64(input logic [63:0] p, input logic n);
        return n ? (~p + 64'd1) : p;
    endfunction

    logic [2*DATA_WIDTH-1:0] corr_p0;
    logic [DATA_WIDTH-1:0]   sel_p0;
    logic                    illegal_p0;
    logic                    sel_hi;

    logic [DATA_WIDTH-1:0]   buf_result [2];
    logic                    buf_illegal [2];
    logic                    wptr;
    logic                    rptr;
    logic [1:0]              count;
    logic                    push;
    logic                    pop;

    // Stage p0: combinational correction and lane-half selection
    always_comb begin
        corr_p0    = '0;
        sel_p0     = '0;
        illegal_p0 = 1'b0;
        sel_hi     = (opcode_in != OP_MUL);
        case (precision_in)
            PREC_8: begin
                for (int i = 0; i < 4; i++) begin
                    corr_p0[16*i +: 16] = neg_lane16(product_in[16*i +: 16], neg_in[i]);
                    sel_p0[8*i +: 8]    = sel_hi ? corr_p0[16*i+8 +: 8] : corr_p0[16*i +: 8];
                end
            end
            PREC_16: begin
                for (int i = 0; i < 2; i++) begin
                    corr_p0[32*i +: 32] = neg_lane32(product_in[32*i +: 32], neg_in[i]);
                    sel_p0[16*i +: 16]  = sel_hi ? corr_p0[32*i+16 +: 16] : corr_p0[32*i +: 16];
                end
            end
            PREC_32: begin
                corr_p0 = neg_lane64(product_in, neg_in[0]);
                sel_p0  = sel_hi ? corr_p0[63:32] : corr_p0[31:0];
            end
            default: begin
                illegal_p0 = 1'b1;
            end
        endcase
    end

    assign ready_in    = (count != 2'(BUF_DEPTH));
    assign valid_out   = (count != 2'd0);
    assign push        = valid_in && ready_in;
    assign pop         = valid_out && ready_out;
    assign result_out  = buf_result[rptr];
    assign illegal_out = buf_illegal[rptr];

    // Stage p1: output buffer; the head is read straight from registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= 2'd0;
            wptr           <= 1'b0;
            rptr           <= 1'b0;
            buf_result[0]  <= '0;
            buf_result[1]  <= '0;
            buf_illegal[0] <= 1'b0;
            buf_illegal[1] <= 1'b0;
        end else begin
            if (push) begin
                buf_result[wptr]  <= sel_p0;
                buf_illegal[wptr] <= illegal_p0;
                wptr              <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_result_output_stage.sv
// Directed bench for vedic_result_output_stage with hand-computed expectations.
module tb_vedic_result_output_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [63:0] product_in;
    logic [3:0]  neg_in;
    logic [1:0]  opcode_in;
    logic [1:0]  precision_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] result_out;
    logic        illegal_out;

    int tests_run;
    int tests_failed;

    vedic_result_output_stage #(.DATA_WIDTH(32), .BUF_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .product_in(product_in),
        .neg_in(neg_in),
        .opcode_in(opcode_in),
        .precision_in(precision_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .result_out(result_out),
        .illegal_out(illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] prec, input logic [1:0] op,
                         input logic [63:0] prod, input logic [3:0] neg);
        valid_in     = 1'b1;
        precision_in = prec;
        opcode_in    = op;
        product_in   = prod;
        neg_in       = neg;
    endtask

    task automatic idle_inputs();
        valid_in     = 1'b0;
        product_in   = 64'hDEAD_BEEF_CAFE_F00D;
        neg_in       = 4'hF;
        opcode_in    = 2'b01;
        precision_in = 2'b00;
    endtask

    task automatic send(input logic [1:0] prec, input logic [1:0] op,
                        input logic [63:0] prod, input logic [3:0] neg);
        drive(prec, op, prod, neg);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        ready_out    = 1'b1;
        idle_inputs();
        repeat (2) tick();
        check_val("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check_val("rst_ready_in", {31'd0, ready_in}, 32'd1);
        check_val("rst_result", result_out, 32'd0);
        check_val("rst_illegal", {31'd0, illegal_out}, 32'd0);
        rst = 1'b0;
        tick();

        // prec 32, MUL of 6, held at head with ready_out low
        ready_out = 1'b0;
        send(2'b10, 2'b00, 64'h6, 4'b0000);
        check_val("mul32_valid", {31'd0, valid_out}, 32'd1);
        check_val("mul32_result", result_out, 32'h0000_0006);

        // reset with one entry stored and a beat offered on the reset cycle
        rst = 1'b1;
        drive(2'b10, 2'b00, 64'h7, 4'b0000);
        tick();
        rst = 1'b0;
        idle_inputs();
        check_val("midrst_valid", {31'd0, valid_out}, 32'd0);
        check_val("midrst_ready", {31'd0, ready_in}, 32'd1);
        tick();
        check_val("midrst_no_accept", {31'd0, valid_out}, 32'd0);
        ready_out = 1'b1;

        // back-to-back beats: each push lands while the previous head pops
        send(2'b10, 2'b01, 64'h6, 4'b0001);
        check_val("mulh32_neg", result_out, 32'hFFFF_FFFF);
        send(2'b10, 2'b00, 64'h6, 4'b0001);
        check_val("mul32_neg", result_out, 32'hFFFF_FFFA);
        check_val("pushpop_c1_valid", {31'd0, valid_out}, 32'd1);
        check_val("pushpop_c1_ready", {31'd0, ready_in}, 32'd1);
        send(2'b00, 2'b00, 64'h0001_0000_00FF_0010, 4'b1001);
        check_val("mul8_lanes", result_out, 32'hFF00_FFF0);
        send(2'b00, 2'b10, 64'h0001_0000_00FF_0010, 4'b1001);
        check_val("mulhu8_lanes", result_out, 32'hFF00_00FF);
        send(2'b01, 2'b01, 64'h0001_0000_0000_0001, 4'b0001);
        check_val("mulh16_lanes", result_out, 32'h0001_FFFF);
        send(2'b01, 2'b00, 64'h0000_0000_0000_1234, 4'b0010);
        check_val("mul16_negzero", result_out, 32'h0000_1234);
        tick();
        check_val("drained_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check_val("xsafe_valid", {31'd0, valid_out}, 32'd0);

        // back-pressure: A, B fill the buffer, C waits upstream
        ready_out = 1'b0;
        send(2'b10, 2'b00, 64'hA, 4'b0000);
        check_val("bp_a_ready", {31'd0, ready_in}, 32'd1);
        send(2'b10, 2'b00, 64'hB, 4'b0000);
        check_val("bp_full_ready", {31'd0, ready_in}, 32'd0);
        check_val("bp_head_a", result_out, 32'hA);
        drive(2'b10, 2'b00, 64'hC, 4'b0000);
        tick();
        check_val("bp_hold_a", result_out, 32'hA);
        check_val("bp_hold_ready", {31'd0, ready_in}, 32'd0);
        ready_out = 1'b1;
        tick();
        check_val("bp_head_b", result_out, 32'hB);
        check_val("bp_ready_back", {31'd0, ready_in}, 32'd1);
        tick();
        idle_inputs();
        check_val("bp_head_c", result_out, 32'hC);
        check_val("bp_c_valid", {31'd0, valid_out}, 32'd1);
        tick();
        check_val("bp_empty", {31'd0, valid_out}, 32'd0);

        // reserved precision followed by a legal beat
        ready_out = 1'b0;
        send(2'b11, 2'b00, 64'h1234_5678_9ABC_DEF0, 4'b0000);
        check_val("ill_flag", {31'd0, illegal_out}, 32'd1);
        check_val("ill_result", result_out, 32'd0);
        check_val("ill_valid", {31'd0, valid_out}, 32'd1);
        ready_out = 1'b1;
        send(2'b10, 2'b00, 64'h55, 4'b0000);
        check_val("post_ill_flag", {31'd0, illegal_out}, 32'd0);
        check_val("post_ill_result", result_out, 32'h55);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
